xps2_rx: RTL

//  PS/2 keyboard receiver for the calculator. Receives host-bound 11-bit frames from ps2_clk/ps2_data.

---
 rtl/xps2_rx_pkg.sv | 28 ++
 rtl/xps2_rx_fifo.sv | 71 +++++++
 rtl/xps2_rx.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/xps2_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM states, register
// addresses, STATUS bit positions and the frame check helper.
package xps2_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int unsigned STAT_NEMPTY  = 0;
  localparam int unsigned STAT_PERR    = 1;
  localparam int unsigned STAT_FERR    = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 8;

  // Odd parity over byte+parity bit.
  function automatic logic parity_ok(input logic [7:0] b, input logic par);
    return (^b) ^ par;
  endfunction

endpackage

// File: rtl/xps2_rx_fifo.sv
// xps2_fifo: synchronous scan-code FIFO.
// Ports: clk, rst (sync, active-high), push/din, pop, flush (wins over
// push/pop), dout (head, combinational), full, empty, count.
// A push while full is dropped; a pop while empty is ignored.
module xps2_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rd_q];
  assign count = cnt_q;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/xps2_rx.sv
// xps2_rx: PS/2 keyboard receiver, polled as a memory-mapped peripheral.
// Ports: clk, rst (sync, active-high), ps2_clk/ps2_data (async pads),
// sel/we/addr/data_in (bus access strobe), data_out (registered read data),
// rx_valid (FIFO not empty).
// Registers: 0 STATUS (R), 1 DATA (R, pops), 2 CTRL (W: [0] clear flags,
// [1] flush FIFO), 3 reserved.
module xps2_rx
  import xps2_rx_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rx_valid
);

  localparam int unsigned CW   = $clog2(DEPTH) + 1;
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC) + 1;

  logic [2:0]        ps2c_s_q, ps2c_s_d, ps2d_s_q, ps2d_s_d;
  rx_state_e         state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;

  logic              fall, din_s;
  logic              push, pop, flush, clr;
  logic              set_perr, set_ferr;
  logic [7:0]        fifo_dout;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_cnt;
  logic [DATA_W-1:0] status;
  logic              unused_data_in;

  assign unused_data_in = ^data_in[DATA_W-1:2];

  assign fall  = (ps2c_s_q[2:1] == 2'b10);
  assign din_s = ps2d_s_q[1];

  xps2_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (shift_q),
    .pop   (pop),
    .flush (flush),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign rx_valid = ~fifo_empty;
  assign data_out = data_out_q;

  always_comb begin
    status                           = '0;
    status[STAT_NEMPTY]              = ~fifo_empty;
    status[STAT_PERR]                = perr_q;
    status[STAT_FERR]                = ferr_q;
    status[STAT_OVF]                 = ovf_q;
    status[STAT_CNT_LSB +: 4]        = 4'(fifo_cnt);
  end

  always_comb begin
    ps2c_s_d   = {ps2c_s_q[1:0], ps2_clk};
    ps2d_s_d   = {ps2d_s_q[1:0], ps2_data};
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    push       = 1'b0;
    set_perr   = 1'b0;
    set_ferr   = 1'b0;

    if (state_q == ST_IDLE || fall) to_cnt_d = '0;
    else                            to_cnt_d = to_cnt_q + TO_W'(1);

    // Timeout takes priority over a coincident fall edge.
    if (state_q != ST_IDLE && to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
      state_d  = ST_IDLE;
      set_ferr = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!din_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {din_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = din_s;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          push     = din_s & parity_ok(shift_q, par_q);
          set_perr = ~parity_ok(shift_q, par_q);
          set_ferr = ~din_s;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    data_out_d = data_out_q;
    pop        = 1'b0;
    clr        = 1'b0;
    flush      = 1'b0;
    if (sel && !we) begin
      unique case (addr)
        ADDR_STATUS: data_out_d = status;
        ADDR_DATA: begin
          data_out_d = '0;
          if (!fifo_empty) begin
            data_out_d[7:0] = fifo_dout;
            pop             = 1'b1;
          end
        end
        default: data_out_d = '0;
      endcase
    end
    if (sel && we && addr == ADDR_CTRL) begin
      clr   = data_in[0];
      flush = data_in[1];
    end
    perr_d = (perr_q & ~clr) | set_perr;
    ferr_d = (ferr_q & ~clr) | set_ferr;
    ovf_d  = (ovf_q & ~clr) | (push & fifo_full);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps2c_s_q   <= '1;
      ps2d_s_q   <= '1;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      ps2c_s_q   <= ps2c_s_d;
      ps2d_s_q   <= ps2d_s_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
      data_out_q <= data_out_d;
    end
  end

endmodule
